// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage of the 9-bit CPU. Owns the program counter, drives
// the synchronous instruction ROM (one cycle read latency) and presents one
// 9-bit instruction per cycle to the decoder. Applies lookup-jump, absolute
// jump and PC-relative branch redirects on accept cycles. It halts when the
// done instruction (9'h1FF) is accepted.
//
// Ports:
//   clk          in   1     clock, all state on the rising edge
//   reset        in   1     synchronous active-high reset
//   start        in   1     begin execution at START_PC (from IDLE or HALT)
//   imem_addr    out  PC_W  ROM address (the PC)
//   imem_data    in   9     ROM read data, valid one cycle after imem_addr
//   instr        out  9     instruction to the decoder
//   instr_pc     out  PC_W  address of instr
//   instr_valid  out  1     instr is live
//   stall        in   1     decoder cannot accept instr this cycle
//   jump_en      in   1     absolute redirect to jump_tgt
//   jump_tgt     in   PC_W  absolute target
//   branch_en    in   1     relative redirect by branch_off
//   branch_off   in   8     signed offset relative to instr_pc
//   ljp_en       in   1     lookup redirect
//   ljp_sel      in   2     selects LJn_ADDR
//   cycle_count  out  16    RUN cycle counter (only with FETCH_CYCLE_COUNT_EN)
//   done         out  1     program finished
//
// Optional feature macro: FETCH_CYCLE_COUNT_EN adds the saturating 16-bit
// cycle_count output. Without it the port and counter are absent.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned     PC_W     = 10,
    parameter logic [PC_W-1:0] START_PC = {PC_W{1'b0}},
    parameter logic [PC_W-1:0] LJ0_ADDR = {PC_W{1'b0}},
    parameter logic [PC_W-1:0] LJ1_ADDR = {PC_W{1'b0}},
    parameter logic [PC_W-1:0] LJ2_ADDR = {PC_W{1'b0}},
    parameter logic [PC_W-1:0] LJ3_ADDR = {PC_W{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    input  logic [8:0]      imem_data,
    output logic [8:0]      instr,
    output logic [PC_W-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            stall,
    input  logic            jump_en,
    input  logic [PC_W-1:0] jump_tgt,
    input  logic            branch_en,
    input  logic [7:0]      branch_off,
    input  logic            ljp_en,
    input  logic [1:0]      ljp_sel,
`ifdef FETCH_CYCLE_COUNT_EN
    output logic [15:0]     cycle_count,
`endif
    output logic            done
);

    localparam logic [8:0] DONE_INSTR = 9'h1FF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    // A fetch issued last cycle whose data is on imem_data now.
    logic            fetch_vld_q, fetch_vld_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    // Capture of a stalled instruction; the ROM output moves on underneath it.
    logic            hold_vld_q, hold_vld_d;
    logic [8:0]      hold_instr_q, hold_instr_d;
    logic [PC_W-1:0] hold_pc_q, hold_pc_d;
    logic            done_q, done_d;
`ifdef FETCH_CYCLE_COUNT_EN
    logic [15:0]     cnt_q, cnt_d;
`endif

    logic [8:0]      cur_instr_s;
    logic [PC_W-1:0] cur_pc_s;
    logic            cur_vld_s;
    logic            accept_s;
    logic [PC_W-1:0] pc_inc_s;
    logic [PC_W-1:0] off_ext_s;
    logic [PC_W-1:0] br_tgt_s;
    logic [PC_W-1:0] lj_tgt_s;

    // Presented instruction: the stall capture wins over the live ROM data.
    always_comb begin
        if (hold_vld_q) begin
            cur_instr_s = hold_instr_q;
            cur_pc_s    = hold_pc_q;
            cur_vld_s   = 1'b1;
        end else if (fetch_vld_q) begin
            cur_instr_s = imem_data;
            cur_pc_s    = fetch_pc_q;
            cur_vld_s   = 1'b1;
        end else begin
            cur_instr_s = 9'h000;
            cur_pc_s    = {PC_W{1'b0}};
            cur_vld_s   = 1'b0;
        end
    end

    assign accept_s  = cur_vld_s & ~stall;
    assign pc_inc_s  = pc_q + PC_W'(1'b1);
    // Sign-extend the 8-bit offset to the PC width; the add wraps modulo 2^PC_W.
    assign off_ext_s = PC_W'($signed(branch_off));
    assign br_tgt_s  = cur_pc_s + off_ext_s;

    // Lookup-jump target table.
    always_comb begin
        case (ljp_sel)
            2'd0:    lj_tgt_s = LJ0_ADDR;
            2'd1:    lj_tgt_s = LJ1_ADDR;
            2'd2:    lj_tgt_s = LJ2_ADDR;
            2'd3:    lj_tgt_s = LJ3_ADDR;
            default: lj_tgt_s = LJ0_ADDR;
        endcase
    end

    // Next-state logic: FSM transitions, PC update, fetch tracking, stall capture.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_vld_d  = 1'b0;
        fetch_pc_d   = fetch_pc_q;
        hold_vld_d   = hold_vld_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        done_d       = done_q;
`ifdef FETCH_CYCLE_COUNT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d    = ST_RUN;
                    pc_d       = START_PC;
                    hold_vld_d = 1'b0;
                    done_d     = 1'b0;
`ifdef FETCH_CYCLE_COUNT_EN
                    // Fetch begins on the start cycle, so it is the first counted cycle.
                    cnt_d      = 16'd1;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
`ifdef FETCH_CYCLE_COUNT_EN
                if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q;
                end
`endif
                if (accept_s) begin
                    hold_vld_d = 1'b0;
                    if (cur_instr_s == DONE_INSTR) begin
                        // Halting squashes the in-flight fetch and ignores redirects.
                        state_d = ST_HALT;
                        done_d  = 1'b1;
                    end else if (ljp_en) begin
                        pc_d = lj_tgt_s;
                    end else if (jump_en) begin
                        pc_d = jump_tgt;
                    end else if (branch_en) begin
                        pc_d = br_tgt_s;
                    end else begin
                        fetch_vld_d = 1'b1;
                        fetch_pc_d  = pc_q;
                        pc_d        = pc_inc_s;
                    end
                end else if (cur_vld_s) begin
                    // Stalled: freeze the PC and capture what is presented.
                    hold_vld_d   = 1'b1;
                    hold_instr_d = cur_instr_s;
                    hold_pc_d    = cur_pc_s;
                end else begin
                    // Pipe empty (start or post-redirect bubble): issue the PC.
                    fetch_vld_d = 1'b1;
                    fetch_pc_d  = pc_q;
                    pc_d        = pc_inc_s;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                pc_d       = START_PC;
                hold_vld_d = 1'b0;
                done_d     = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= START_PC;
            fetch_vld_q  <= 1'b0;
            fetch_pc_q   <= {PC_W{1'b0}};
            hold_vld_q   <= 1'b0;
            hold_instr_q <= 9'h000;
            hold_pc_q    <= {PC_W{1'b0}};
            done_q       <= 1'b0;
`ifdef FETCH_CYCLE_COUNT_EN
            cnt_q        <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_vld_q  <= fetch_vld_d;
            fetch_pc_q   <= fetch_pc_d;
            hold_vld_q   <= hold_vld_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            done_q       <= done_d;
`ifdef FETCH_CYCLE_COUNT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign imem_addr   = pc_q;
    assign instr       = cur_instr_s;
    assign instr_pc    = cur_pc_s;
    assign instr_valid = cur_vld_s;
    assign done        = done_q;
`ifdef FETCH_CYCLE_COUNT_EN
    assign cycle_count = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. A transaction-level reference model
// tracks the next expected instruction address and the number of empty
// cycles before it appears; every cycle the DUT outputs are compared against
// it. Directed phases cover the straight-line run across the PC wrap, stall
// hold, redirects, priority, done-with-redirect and reset mid-stall; a
// randomized phase follows.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int         PC_W  = 10;
    localparam logic [9:0] START = 10'h3FE;
    localparam logic [9:0] LJ0   = 10'h040;
    localparam logic [9:0] LJ1   = 10'h080;
    localparam logic [9:0] LJ2   = 10'h100;
    localparam logic [9:0] LJ3   = 10'h200;

    logic       clk = 1'b0;
    logic       reset, start, stall;
    logic       jump_en, branch_en, ljp_en;
    logic [9:0] jump_tgt;
    logic [7:0] branch_off;
    logic [1:0] ljp_sel;
    logic [9:0] imem_addr;
    logic [8:0] imem_data;
    logic [8:0] instr;
    logic [9:0] instr_pc;
    logic       instr_valid;
    logic       done;
`ifdef FETCH_CYCLE_COUNT_EN
    logic [15:0] cycle_count;
`endif

    logic [8:0] rom [0:1023];

    int errors = 0;
    int checks = 0;

    // Reference model: 0 idle, 1 run, 2 halt.
    int          m_state = 0;
    logic [9:0]  m_pc    = 10'h000;
    int          m_lat   = 0;
    logic        m_done  = 1'b0;
    logic [15:0] m_cnt   = 16'd0;

    always #5 clk = ~clk;

    // Synchronous ROM, one cycle read latency.
    always @(posedge clk) imem_data <= rom[imem_addr];

    fetch_unit #(
        .PC_W     (PC_W),
        .START_PC (START),
        .LJ0_ADDR (LJ0),
        .LJ1_ADDR (LJ1),
        .LJ2_ADDR (LJ2),
        .LJ3_ADDR (LJ3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .stall       (stall),
        .jump_en     (jump_en),
        .jump_tgt    (jump_tgt),
        .branch_en   (branch_en),
        .branch_off  (branch_off),
        .ljp_en      (ljp_en),
        .ljp_sel     (ljp_sel),
`ifdef FETCH_CYCLE_COUNT_EN
        .cycle_count (cycle_count),
`endif
        .done        (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [9:0] lj_addr(input logic [1:0] sel);
        case (sel)
            2'd0:    return LJ0;
            2'd1:    return LJ1;
            2'd2:    return LJ2;
            default: return LJ3;
        endcase
    endfunction

    task automatic clear_inputs();
        reset = 1'b0; start = 1'b0; stall = 1'b0;
        jump_en = 1'b0; branch_en = 1'b0; ljp_en = 1'b0;
        jump_tgt = 10'h000; branch_off = 8'h00; ljp_sel = 2'd0;
    endtask

    // Predict the coming clock edge from the current inputs, then compare.
    task automatic tick();
        logic exp_v;
        if (reset) begin
            m_state = 0; m_done = 1'b0; m_lat = 0; m_cnt = 16'd0;
        end else if (m_state != 1) begin
            if (start) begin
                m_state = 1; m_pc = START; m_lat = 1; m_done = 1'b0; m_cnt = 16'd1;
            end
        end else begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (m_lat > 0) begin
                m_lat--;
            end else if (!stall) begin
                if (rom[m_pc] == 9'h1FF) begin
                    m_state = 2; m_done = 1'b1;
                end else if (ljp_en) begin
                    m_pc = lj_addr(ljp_sel); m_lat = 1;
                end else if (jump_en) begin
                    m_pc = jump_tgt; m_lat = 1;
                end else if (branch_en) begin
                    m_pc = m_pc + {{2{branch_off[7]}}, branch_off}; m_lat = 1;
                end else begin
                    m_pc = m_pc + 10'd1;
                end
            end
        end
        @(negedge clk);
        exp_v = (m_state == 1) && (m_lat == 0);
        check_eq("instr_valid", {31'd0, instr_valid}, {31'd0, exp_v});
        check_eq("done", {31'd0, done}, {31'd0, m_done});
        if (exp_v) begin
            check_eq("instr_pc", {22'd0, instr_pc}, {22'd0, m_pc});
            check_eq("instr", {23'd0, instr}, {23'd0, rom[m_pc]});
        end
        if (m_state == 0) begin
            check_eq("idle_instr", {23'd0, instr}, 32'd0);
            check_eq("idle_instr_pc", {22'd0, instr_pc}, 32'd0);
            check_eq("idle_imem_addr", {22'd0, imem_addr}, {22'd0, START});
        end
`ifdef FETCH_CYCLE_COUNT_EN
        check_eq("cycle_count", {16'd0, cycle_count}, {16'd0, m_cnt});
`endif
    endtask

    task automatic wait_pc(input logic [9:0] pc);
        int n = 0;
        while (!(m_state == 1 && m_lat == 0 && m_pc == pc) && n < 40) begin
            tick();
            n++;
        end
        check_eq("wait_pc_budget", {31'd0, (n < 40)}, 32'd1);
    endtask

    task automatic run_until_halt();
        int n = 0;
        while (m_state == 1 && n < 60) begin
            tick();
            n++;
        end
        check_eq("halt_budget", {31'd0, (n < 60)}, 32'd1);
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) rom[a] = 9'($urandom_range(0, 510));
        // Straight-line program straddling the PC wrap, ending in done.
        rom[10'h3FE] = 9'h021;
        rom[10'h3FF] = 9'h042;
        rom[10'h000] = 9'h063;
        rom[10'h001] = 9'h1FF;

        clear_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick();

        // Straight-line run: 3FE, 3FF, 000, 001(done), then halt.
        start = 1'b1; tick(); start = 1'b0;
        run_until_halt();
`ifdef FETCH_CYCLE_COUNT_EN
        check_eq("cycle_count_at_done", {16'd0, cycle_count}, 32'd6);
`endif
        tick(); tick(); tick();
`ifdef FETCH_CYCLE_COUNT_EN
        check_eq("cycle_count_frozen", {16'd0, cycle_count}, 32'd6);
`endif

        // Restart from HALT, stall three cycles on 3FF.
        start = 1'b1; tick(); start = 1'b0;
        wait_pc(10'h3FF);
        stall = 1'b1; tick(); tick(); tick(); stall = 1'b0;
        tick();
        // Absolute jump at 000 to 0x020.
        wait_pc(10'h000);
        jump_en = 1'b1; jump_tgt = 10'h020; tick(); jump_en = 1'b0;
        // Branch -3 at 0x021 to 0x01E.
        wait_pc(10'h021);
        branch_en = 1'b1; branch_off = 8'hFD; tick(); branch_en = 1'b0;
        // All three redirects together: lookup wins.
        wait_pc(10'h01E);
        ljp_en = 1'b1; ljp_sel = 2'd2; jump_en = 1'b1; jump_tgt = 10'h050;
        branch_en = 1'b1; branch_off = 8'h05;
        tick();
        clear_inputs();
        wait_pc(10'h100);
        tick(); tick();
        // Reset in the middle of a stall.
        stall = 1'b1; tick();
        reset = 1'b1; tick();
        reset = 1'b0; stall = 1'b0; tick(); tick();
        // Clean restart; a redirect coincident with done is ignored.
        start = 1'b1; tick(); start = 1'b0;
        wait_pc(10'h001);
        jump_en = 1'b1; jump_tgt = 10'h020; tick(); jump_en = 1'b0;
        tick(); tick();

        // Randomized phase with scattered done instructions.
        for (int a = 0; a < 1024; a++) begin
            if ($urandom_range(0, 31) == 0) rom[a] = 9'h1FF;
        end
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 499) == 0);
            start      = (m_state != 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
            stall      = ($urandom_range(0, 3) == 0);
            jump_en    = ($urandom_range(0, 7) == 0);
            jump_tgt   = 10'($urandom);
            branch_en  = ($urandom_range(0, 7) == 0);
            branch_off = 8'($urandom);
            ljp_en     = ($urandom_range(0, 9) == 0);
            ljp_sel    = 2'($urandom);
            tick();
        end
        clear_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 9-bit CPU. It owns the program counter, drives the synchronous instruction ROM, and presents one 9-bit instruction (5-bit opcode + 4-bit operand) per cycle to the decoder. It applies redirects from the decoder/execute stage: absolute jump, PC-relative branch, and the four lookup jumps `lj0`..`lj3`. It halts on the `done` instruction.

## Interface
Parameters:
- `PC_W`, 10: program counter / ROM address width.
- `START_PC`, 0: address loaded on `start`.
- `LJ0_ADDR`, `LJ1_ADDR`, `LJ2_ADDR`, `LJ3_ADDR`, 0/0/0/0: lookup-jump targets for `lj0`..`lj3`.

Ports:
- `clk`  in  1  clock; one clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin execution at `START_PC`.
- `imem_addr`  out  PC_W  ROM address; ROM returns data one cycle later.
- `imem_data`  in  9  ROM read data.
- `instr`  out  9  instruction to decoder.
- `instr_pc`  out  PC_W  address of `instr`.
- `instr_valid`  out  1  `instr` is live.
- `stall`  in  1  decoder cannot accept `instr` this cycle.
- `jump_en`  in  1  absolute redirect to `jump_tgt`.
- `jump_tgt`  in  PC_W  absolute target.
- `branch_en`  in  1  relative redirect.
- `branch_off`  in  8  signed offset, relative to `instr_pc`.
- `ljp_en`  in  1  lookup redirect.
- `ljp_sel`  in  2  selects `LJn_ADDR`.
- `done`  out  1  program finished.

## Operation
- FSM states:
  - IDLE (reset state).
  - RUN.
  - HALT.
- IDLE/HALT + `start` → RUN. PC := `START_PC`. Fetch begins the same cycle.
- `start` is ignored in RUN. In HALT, `start` also clears `done`.
- RUN fetch:
  - `imem_addr` = PC each cycle.
  - PC increments modulo 2^PC_W whenever the decoder accepts an instruction or the pipe is empty.
  - 0x3FF wraps to 0x000 at default width.
- Accept = `instr_valid && !stall`.
- Redirects are sampled only on accept cycles and are ignored otherwise.
- Redirect priority: `ljp_en` > `jump_en` > `branch_en`.
- Redirect targets:
  - Branch target = `instr_pc` + sign-extended `branch_off`, modulo 2^PC_W.
  - Jump and ljp targets are used as given.
- Redirect handling:
  - The in-flight fetch is squashed and never presented.
  - PC := target.
  - Exactly one bubble cycle follows.
- Stall: `instr`, `instr_pc`, `instr_valid` are held stable. No instruction is dropped or duplicated. Use a capture register, because the ROM output changes.
- Halt:
  - Accepting `instr` == 9'h1FF (`func` + `done` operand) enters HALT.
  - The halting instruction counts as accepted.
  - Fetches in flight are squashed.
  - `done`=1 from the next cycle until `start` or `reset`.
  - `instr_valid`=0 in HALT.
- A redirect coincident with the done instruction is ignored.

## Timing
- Reset values:
  - state IDLE.
  - PC = `START_PC`.
  - `imem_addr` = `START_PC`.
  - `instr` = 0.
  - `instr_pc` = 0.
  - `instr_valid` = 0.
  - `done` = 0.
- `reset` overrides everything, including mid-RUN, mid-stall and coincident `start`.
- Fetch latency: `start` at cycle t → `instr_valid`=1 with `instr_pc`=`START_PC` at t+2. The address is issued at t+1, after PC load; data returns at t+2.
- Steady state: one instruction per cycle with no stall.
- Redirect accepted at cycle t:
  - Cycle t+1: `instr_valid`=0 (bubble).
  - Cycle t+2: target instruction valid.
- Redirect and stall are mutually exclusive by construction, since a redirect is only sampled on accept.
- `done` rises 1 cycle after the done instruction is accepted.

## Configuration
- `FETCH_CYCLE_COUNT_EN` defined: adds output `cycle_count` (16 bits).
  - Cleared on `start` and on `reset`.
  - Increments every cycle in RUN.
  - Frozen in HALT.
  - Saturates at 0xFFFF.
- Undefined: the port and counter logic are absent. All other behaviour is identical.

## Test plan
- Straight-line run:
  - Stimulus: ROM 0..3 = `movc`, `movd`, `incr`, 9'h1FF; `start` at cycle 5.
  - Response: valid `instr_pc` 0,1,2,3 at cycles 7–10; `done`=1 at cycle 11; `instr_valid`=0 thereafter.
- Stall hold:
  - Stimulus: `stall` high 3 cycles while `instr_pc`=1.
  - Response: `instr`/`instr_pc` constant; sequence continues 2,3 with no skip or duplicate.
- Redirects:
  - Stimulus A: `jump_en` with `jump_tgt`=0x20 accepted at `instr_pc`=2.
  - Response A: next valid `instr_pc`=0x20 after exactly one bubble.
  - Stimulus B: `branch_off`=-3 at `instr_pc`=0x21.
  - Response B: next valid `instr_pc`=0x1E.
- Priority and lookup:
  - Stimulus: `ljp_en` (`ljp_sel`=2, `LJ2_ADDR`=0x100), `jump_en` (0x50) and `branch_en` all high in one accept cycle.
  - Response: next valid `instr_pc`=0x100.
- Wrap and reset:
  - Stimulus: `START_PC`=0x3FE.
  - Response: `instr_pc` 0x3FE, 0x3FF, 0x000.
  - Stimulus: `reset` mid-stall.
  - Response: IDLE with all outputs at reset values; then `start` restarts cleanly.
- With `FETCH_CYCLE_COUNT_EN`:
  - Stimulus: rerun scenario 1.
  - Response: `cycle_count`=6 at `done`, and it holds 6 in HALT.
